// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle MIPS sequencer and its datapath.
// The master side is the sequencer: it consumes run/opcode/memory status
// and drives every mux select and write enable of the datapath.
interface multicycle_ctrl_fsm_if;
  // Status into the sequencer
  logic       start_i;
  logic [5:0] op_i;
  logic       mem_ready_i;

  // Datapath controls out of the sequencer
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       mem_to_reg_o;
  logic       reg_dst_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic [1:0] pc_source_o;
  logic [3:0] state_o;
  logic       illegal_o;

  modport master (
    input  start_i, op_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, pc_source_o, state_o, illegal_o
  );

  modport slave (
    output start_i, op_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, pc_source_o, state_o, illegal_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Control sequencer for a multi-cycle MIPS datapath with one shared memory.
// Each instruction walks FETCH -> DECODE -> (class-specific states) and
// returns to FETCH, or parks in IDLE when start_i is low at the end of an
// instruction. Memory states stall on mem_ready_i. Apart from the FETCH
// commit strobes and the DECODE illegal-opcode pulse, every output is a
// pure decode of the current state.
module multicycle_ctrl_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state;
  state_t state_next;

  // With waiting disabled every memory access is assumed to finish in one cycle.
  logic ready;
  assign ready = MEM_WAIT_EN ? bus.mem_ready_i : 1'b1;

  // Where an instruction goes once it has completed: keep running or park.
  state_t after_done;
  assign after_done = bus.start_i ? FETCH : IDLE;

  logic op_legal;

  // Opcode classification used by DECODE for dispatch and the illegal pulse.
  always_comb begin
    op_legal = 1'b0;
    case (bus.op_i)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // State register; reset parks the sequencer in IDLE without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: memory states hold until ready, completion states
  // sample start_i to decide between the next fetch and IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start_i) state_next = FETCH;
      end
      FETCH: begin
        if (ready) state_next = DECODE;
      end
      DECODE: begin
        case (bus.op_i)
          OP_RTYPE:     state_next = EXEC;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          // Unsupported opcode retires as a NOP.
          default:      state_next = after_done;
        endcase
      end
      MEMADR: begin
        state_next = (bus.op_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        if (ready) state_next = MEMWB;
      end
      MEMWR: begin
        if (ready) state_next = after_done;
      end
      EXEC:   state_next = RWB;
      ADDIEX: state_next = ADDIWB;
      MEMWB, RWB, BRANCH, ADDIWB, JUMP: state_next = after_done;
      // Codes 13-15 are never entered in normal operation; recover to IDLE.
      default: state_next = IDLE;
    endcase
  end

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal;

  // Datapath control decode; everything defaults to 0 so IDLE and the
  // unreachable codes drive an all-quiet datapath.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    case (state)
      FETCH: begin
        // Read at PC while the ALU forms PC+4; the PC update and IR load
        // only commit in the cycle the memory returns the word.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_write  = ready;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        illegal   = ~op_legal;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.pc_write_o      = pc_write;
  assign bus.pc_write_cond_o = pc_write_cond;
  assign bus.i_or_d_o        = i_or_d;
  assign bus.mem_read_o      = mem_read;
  assign bus.mem_write_o     = mem_write;
  assign bus.ir_write_o      = ir_write;
  assign bus.mem_to_reg_o    = mem_to_reg;
  assign bus.reg_dst_o       = reg_dst;
  assign bus.reg_write_o     = reg_write;
  assign bus.alu_src_a_o     = alu_src_a;
  assign bus.alu_src_b_o     = alu_src_b;
  assign bus.alu_op_o        = alu_op;
  assign bus.pc_source_o     = pc_source;
  assign bus.state_o         = state;
  assign bus.illegal_o       = illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for the multi-cycle control sequencer. Instructions are described
// at the level of "opcode + fetch waits + memory waits + start at the end";
// the expected per-cycle state trace and control word come from the
// instruction class rules and the per-state control table.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Bit positions inside the packed 17-bit control word
  localparam int B_PW  = 16;
  localparam int B_PWC = 15;
  localparam int B_IOD = 14;
  localparam int B_MR  = 13;
  localparam int B_MW  = 12;
  localparam int B_IRW = 11;
  localparam int B_M2R = 10;
  localparam int B_RW  = 8;
  localparam int B_ILL = 0;

  logic clk;
  logic rst;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st;
    logic [5:0] op;
    logic       rdy;
    int         es;
  } entry_t;

  entry_t      plan[$];
  int          obs_state[$];
  logic [16:0] obs_out[$];
  bit          in_idle;

  function automatic bit is_legal(logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Expected control word for a state code, given this cycle's ready/opcode.
  function automatic logic [16:0] exp_out(int s, logic rdy, logic [5:0] op);
    logic pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    pw = 0; pwc = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0;
    rdst = 0; rw = 0; asa = 0; ill = 0; asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      1:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      2:  begin asb = 2'b11; ill = !is_legal(op); end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mw = 1; iod = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      12: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  function automatic logic [16:0] dut_out();
    return {bus.pc_write_o, bus.pc_write_cond_o, bus.i_or_d_o, bus.mem_read_o,
            bus.mem_write_o, bus.ir_write_o, bus.mem_to_reg_o, bus.reg_dst_o,
            bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o,
            bus.pc_source_o, bus.illegal_o};
  endfunction

  // Append one instruction to the plan. mid selects start_i while the
  // instruction is in flight: 0/1 constant, 2 random. se is start_i on the
  // final cycle, which decides between the next FETCH and IDLE.
  task automatic push_instr(input logic [5:0] op, input int fw, input int mw,
                            input logic se, input int mid);
    int   sts[$];
    logic rds[$];
    logic st;
    if (in_idle) plan.push_back('{1'b1, 6'($urandom), 1'($urandom), 0});
    for (int i = 0; i < fw; i++) begin sts.push_back(1); rds.push_back(1'b0); end
    sts.push_back(1); rds.push_back(1'b1);
    sts.push_back(2); rds.push_back(1'($urandom));
    case (op)
      OP_LW: begin
        sts.push_back(3); rds.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin sts.push_back(4); rds.push_back(1'b0); end
        sts.push_back(4); rds.push_back(1'b1);
        sts.push_back(5); rds.push_back(1'($urandom));
      end
      OP_SW: begin
        sts.push_back(3); rds.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin sts.push_back(6); rds.push_back(1'b0); end
        sts.push_back(6); rds.push_back(1'b1);
      end
      OP_R:    begin sts.push_back(7);  rds.push_back(1'($urandom));
                     sts.push_back(8);  rds.push_back(1'($urandom)); end
      OP_ADDI: begin sts.push_back(10); rds.push_back(1'($urandom));
                     sts.push_back(11); rds.push_back(1'($urandom)); end
      OP_BEQ:  begin sts.push_back(9);  rds.push_back(1'($urandom)); end
      OP_J:    begin sts.push_back(12); rds.push_back(1'($urandom)); end
      default: ;
    endcase
    for (int i = 0; i < sts.size(); i++) begin
      if (i == sts.size() - 1) st = se;
      else if (mid == 2)       st = 1'($urandom);
      else                     st = (mid != 0);
      plan.push_back('{st, (sts[i] >= 2) ? op : 6'($urandom), rds[i], sts[i]});
    end
    in_idle = !se;
    if (!se) begin
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) plan.push_back('{1'b0, 6'($urandom), 1'($urandom), 0});
    end
  endtask

  // Play the plan one cycle at a time: inputs just after the rising edge,
  // outputs sampled on the falling edge.
  task automatic run_plan();
    entry_t      e;
    logic [16:0] act;
    logic [16:0] exp;
    obs_state.delete();
    obs_out.delete();
    while (plan.size() > 0) begin
      e = plan.pop_front();
      bus.start_i     = e.st;
      bus.op_i        = e.op;
      bus.mem_ready_i = e.rdy;
      @(negedge clk);
      act = dut_out();
      exp = exp_out(e.es, e.rdy, e.op);
      checks++;
      if (bus.state_o !== 4'(e.es)) begin
        errors++;
        $display("FAIL state t=%0t got %0d want %0d", $time, bus.state_o, e.es);
      end
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL controls t=%0t state %0d got %b want %b", $time, e.es, act, exp);
      end
      checks++;
      if ((act[B_MR] && act[B_MW]) || (act[B_RW] && act[B_PW])) begin
        errors++;
        $display("FAIL exclusive t=%0t got %b want no rd+wr / regw+pcw", $time, act);
      end
      obs_state.push_back(int'(bus.state_o));
      obs_out.push_back(act);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input logic st, input logic [5:0] op, input logic rdy);
    bus.start_i = st; bus.op_i = op; bus.mem_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b1; bus.op_i = OP_LW; bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.state_o !== 4'd0 || dut_out() !== 17'd0) begin
        errors++;
        $display("FAIL reset_hold got state %0d ctl %b want 0 0", bus.state_o, dut_out());
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_release got %0d want 0", bus.state_o);
    end
    in_idle = 1'b1;
  endtask

  task automatic test_lw();
    int want[$] = '{1, 2, 3, 4, 5};
    int rw_cnt = 0;
    push_instr(OP_LW, 0, 0, 1'b1, 1);
    plan.pop_front();            // the IDLE start cycle
    apply(1'b1, 6'd0, 1'b0);     // leave IDLE toward FETCH
    run_plan();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_state[i] !== want[i]) begin
        errors++;
        $display("FAIL lw_seq idx %0d got %0d want %0d", i, obs_state[i], want[i]);
      end
      if (obs_out[i][B_RW]) begin
        rw_cnt++;
        checks++;
        if (obs_state[i] !== 5 || !obs_out[i][B_M2R]) begin
          errors++;
          $display("FAIL lw_regwrite got state %0d m2r %0b want 5 1", obs_state[i], obs_out[i][B_M2R]);
        end
      end
    end
    checks++;
    if (rw_cnt !== 1) begin
      errors++;
      $display("FAIL lw_regwrite_count got %0d want 1", rw_cnt);
    end
  endtask

  task automatic test_sw_wait();
    int n6 = 0;
    int bad = 0;
    push_instr(OP_SW, 0, 3, 1'b1, 1);
    run_plan();
    foreach (obs_state[i]) begin
      if (obs_state[i] == 6) begin
        n6++;
        if (!obs_out[i][B_MW] || !obs_out[i][B_IOD]) bad++;
      end
      if (obs_out[i][B_RW]) bad++;
    end
    checks++;
    if (n6 !== 4 || bad !== 0) begin
      errors++;
      $display("FAIL sw_wait got memwr_cycles %0d bad %0d want 4 0", n6, bad);
    end
  endtask

  task automatic test_fetch_wait();
    int pw_idx = -1;
    int pw_cnt = 0;
    int ir_cnt = 0;
    push_instr(OP_R, 2, 0, 1'b1, 1);
    run_plan();
    foreach (obs_out[i]) begin
      if (obs_out[i][B_PW]) begin pw_cnt++; pw_idx = i; end
      if (obs_out[i][B_IRW]) ir_cnt++;
    end
    checks++;
    if (pw_cnt !== 1 || ir_cnt !== 1 || pw_idx !== 2 || !obs_out[2][B_IRW]) begin
      errors++;
      $display("FAIL fetch_wait got pw %0d ir %0d at %0d want 1 1 at 2", pw_cnt, ir_cnt, pw_idx);
    end
  endtask

  task automatic test_illegal();
    int ill_cnt = 0;
    int writes  = 0;
    push_instr(OP_BAD, 0, 0, 1'b1, 1);
    run_plan();
    foreach (obs_out[i]) begin
      if (obs_out[i][B_ILL]) begin
        ill_cnt++;
        checks++;
        if (obs_state[i] !== 2) begin
          errors++;
          $display("FAIL illegal_state got %0d want 2", obs_state[i]);
        end
      end
      if (obs_state[i] != 1 &&
          (obs_out[i][B_RW] || obs_out[i][B_MW] || obs_out[i][B_PW] || obs_out[i][B_PWC]))
        writes++;
    end
    #2;
    checks++;
    if (ill_cnt !== 1 || writes !== 0 || bus.state_o !== 4'd1) begin
      errors++;
      $display("FAIL illegal got pulses %0d writes %0d next %0d want 1 0 1",
               ill_cnt, writes, bus.state_o);
    end
  endtask

  task automatic test_start_drop();
    int rwb_idx = -1;
    push_instr(OP_R, 0, 0, 1'b0, 0);
    push_instr(OP_J, 0, 0, 1'b1, 1);
    run_plan();
    foreach (obs_state[i]) if (obs_state[i] == 8 && rwb_idx < 0) rwb_idx = i;
    checks++;
    if (rwb_idx < 0 || !obs_out[rwb_idx][B_RW] || obs_state[rwb_idx + 1] !== 0) begin
      errors++;
      $display("FAIL start_drop got rwb_idx %0d next %0d want RWB with regw then 0",
               rwb_idx, (rwb_idx < 0) ? -1 : obs_state[rwb_idx + 1]);
    end
  endtask

  task automatic test_async_reset();
    if (in_idle) apply(1'b1, 6'd0, 1'b0);
    apply(1'b1, 6'd0, 1'b1);   // FETCH completes
    apply(1'b1, OP_LW, 1'b0);  // DECODE
    apply(1'b1, OP_LW, 1'b0);  // MEMADR
    bus.mem_ready_i = 1'b0;    // now in MEMRD, stalled
    #1;
    checks++;
    if (bus.state_o !== 4'd4) begin
      errors++;
      $display("FAIL async_pre got %0d want 4", bus.state_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.state_o !== 4'd0 || dut_out() !== 17'd0) begin
      errors++;
      $display("FAIL async_reset got state %0d ctl %b want 0 0", bus.state_o, dut_out());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    in_idle = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] ops[7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BAD};
    logic [5:0] op;
    int         k;
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 6);
      op = (k == 6) ? 6'($urandom) : ops[k];
      push_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 3) != 0), 2);
    end
    run_plan();
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.op_i = 6'd0; bus.mem_ready_i = 1'b0;
    in_idle = 1'b1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_fetch_wait();
    test_illegal();
    test_start_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
